// File: rtl/turret_fire_sched_pkg.sv
// Shared types and constants for the turret fire scheduler.
// The optional ammo limit is enabled with TURRET_FIRE_SCHED_AMMO_LIMIT_EN.
package turret_pkg;

  localparam int COORD_W = 10;

  localparam logic OWNER_L = 1'b0;
  localparam logic OWNER_R = 1'b1;

  typedef enum logic [1:0] {
    READY,
    PENDING,
    COOLDOWN
  } turret_state_t;

  // One captured launch: muzzle position and per-frame step.
  typedef struct packed {
    logic        [COORD_W-1:0] pos_x;
    logic        [COORD_W-1:0] pos_y;
    logic signed [COORD_W-1:0] vel_x;
    logic signed [COORD_W-1:0] vel_y;
  } shot_t;

endpackage

// File: rtl/turret_fire_sched_req_fsm.sv
// Per-turret request tracker: fire-key edge detect, shot capture,
// READY/PENDING/COOLDOWN sequencing and, when
// TURRET_FIRE_SCHED_AMMO_LIMIT_EN is defined, the ammo counter.
module turret_req_fsm
  import turret_pkg::*;
#(
  parameter int COOLDOWN_CYC = 8
`ifdef TURRET_FIRE_SCHED_AMMO_LIMIT_EN
  ,
  parameter int MAX_AMMO     = 15
`endif
) (
  input  logic                      clk2,
  input  logic                      Reset,
  input  logic                      fire,
  input  logic        [COORD_W-1:0] pos_x,
  input  logic        [COORD_W-1:0] pos_y,
  input  logic signed [COORD_W-1:0] vel_x,
  input  logic signed [COORD_W-1:0] vel_y,
  input  logic                      grant,
  output logic                      pending,
  output logic                      busy,
  output shot_t                     shot
`ifdef TURRET_FIRE_SCHED_AMMO_LIMIT_EN
  ,
  output logic                [3:0] ammo
`endif
);

  turret_state_t state, state_nx;
  logic          fire_d;
  logic          req;
  logic          accept;
  logic    [7:0] cnt;

  assign req = fire & ~fire_d;

`ifdef TURRET_FIRE_SCHED_AMMO_LIMIT_EN
  // An empty magazine swallows the press and leaves the turret READY.
  assign accept = req & (ammo != 4'd0);
`else
  assign accept = req;
`endif

  assign pending = (state == PENDING);
  assign busy    = (state != READY);

  // State register.
  always_ff @(posedge clk2) begin
    if (!Reset) state <= READY;
    else        state <= state_nx;
  end

  // Next-state: presses outside READY are dropped, never queued.
  always_comb begin
    state_nx = state;
    case (state)
      READY:    if (accept)      state_nx = PENDING;
      PENDING:  if (grant)       state_nx = COOLDOWN;
      COOLDOWN: if (cnt == 8'd0) state_nx = READY;
      default:                   state_nx = READY;
    endcase
  end

  // Key history and cooldown counter; the counter spans COOLDOWN_CYC cycles.
  always_ff @(posedge clk2) begin
    if (!Reset) begin
      fire_d <= 1'b0;
      cnt    <= 8'd0;
    end else begin
      fire_d <= fire;
      if (state == PENDING && grant)
        cnt <= 8'(COOLDOWN_CYC - 1);
      else if (state == COOLDOWN && cnt != 8'd0)
        cnt <= cnt - 8'd1;
    end
  end

  // Capture the muzzle state at the press so later aiming cannot alter the shot.
  always_ff @(posedge clk2) begin
    if (state == READY && accept)
      shot <= '{pos_x: pos_x, pos_y: pos_y, vel_x: vel_x, vel_y: vel_y};
  end

`ifdef TURRET_FIRE_SCHED_AMMO_LIMIT_EN
  // One round spent per granted launch.
  always_ff @(posedge clk2) begin
    if (!Reset)
      ammo <= 4'(MAX_AMMO);
    else if (state == PENDING && grant)
      ammo <= ammo - 4'd1;
  end
`endif

endmodule

// File: rtl/turret_fire_sched.sv
// Turret fire scheduler: arbitrates left/right launch requests onto a pool
// of bullet engines (lowest free slot, round-robin on contention) and
// registers the launch payload. Optional ammo limit: define
// TURRET_FIRE_SCHED_AMMO_LIMIT_EN to add ammo_l/ammo_r.
module turret_fire_sched
  import turret_pkg::*;
#(
  parameter int NUM_SLOTS    = 4,
  parameter int COOLDOWN_CYC = 8,
  parameter int MAX_AMMO     = 15
) (
  input  logic                      clk2,
  input  logic                      Reset,
  input  logic                      fire_l,
  input  logic                      fire_r,
  input  logic        [COORD_W-1:0] l_pos_x,
  input  logic        [COORD_W-1:0] l_pos_y,
  input  logic signed [COORD_W-1:0] l_vel_x,
  input  logic signed [COORD_W-1:0] l_vel_y,
  input  logic        [COORD_W-1:0] r_pos_x,
  input  logic        [COORD_W-1:0] r_pos_y,
  input  logic signed [COORD_W-1:0] r_vel_x,
  input  logic signed [COORD_W-1:0] r_vel_y,
  input  logic      [NUM_SLOTS-1:0] slot_busy,
  output logic                      spawn_valid,
  output logic                [2:0] spawn_slot,
  output logic                      spawn_owner,
  output logic        [COORD_W-1:0] spawn_pos_x,
  output logic        [COORD_W-1:0] spawn_pos_y,
  output logic signed [COORD_W-1:0] spawn_vel_x,
  output logic signed [COORD_W-1:0] spawn_vel_y,
  output logic                      busy_l,
  output logic                      busy_r
`ifdef TURRET_FIRE_SCHED_AMMO_LIMIT_EN
  ,
  output logic                [3:0] ammo_l,
  output logic                [3:0] ammo_r
`endif
);

  logic                 pend_l, pend_r;
  logic                 grant_l, grant_r, grant_any;
  shot_t                shot_l, shot_r, shot_win;
  logic [NUM_SLOTS-1:0] reserved;
  logic [NUM_SLOTS-1:0] free;
  logic           [1:0] age [NUM_SLOTS];
  logic           [2:0] sel_slot;
  logic                 rr_ptr, rr_ptr_nx;

  logic                 spawn_vld_p1;
  logic           [2:0] spawn_slot_p1;
  logic                 spawn_owner_p1;
  shot_t                shot_p1;

  turret_req_fsm #(
    .COOLDOWN_CYC (COOLDOWN_CYC)
`ifdef TURRET_FIRE_SCHED_AMMO_LIMIT_EN
    ,
    .MAX_AMMO     (MAX_AMMO)
`endif
  ) u_left (
    .clk2    (clk2),
    .Reset   (Reset),
    .fire    (fire_l),
    .pos_x   (l_pos_x),
    .pos_y   (l_pos_y),
    .vel_x   (l_vel_x),
    .vel_y   (l_vel_y),
    .grant   (grant_l),
    .pending (pend_l),
    .busy    (busy_l),
    .shot    (shot_l)
`ifdef TURRET_FIRE_SCHED_AMMO_LIMIT_EN
    ,
    .ammo    (ammo_l)
`endif
  );

  turret_req_fsm #(
    .COOLDOWN_CYC (COOLDOWN_CYC)
`ifdef TURRET_FIRE_SCHED_AMMO_LIMIT_EN
    ,
    .MAX_AMMO     (MAX_AMMO)
`endif
  ) u_right (
    .clk2    (clk2),
    .Reset   (Reset),
    .fire    (fire_r),
    .pos_x   (r_pos_x),
    .pos_y   (r_pos_y),
    .vel_x   (r_vel_x),
    .vel_y   (r_vel_y),
    .grant   (grant_r),
    .pending (pend_r),
    .busy    (busy_r),
    .shot    (shot_r)
`ifdef TURRET_FIRE_SCHED_AMMO_LIMIT_EN
    ,
    .ammo    (ammo_r)
`endif
  );

  // A slot is usable when its engine is idle and no launch is in flight to it.
  assign free      = ~slot_busy & ~reserved;
  assign grant_any = grant_l | grant_r;
  assign shot_win  = grant_r ? shot_r : shot_l;

  // Grant decision: lowest free slot; pointer only moves on contention.
  always_comb begin
    grant_l   = 1'b0;
    grant_r   = 1'b0;
    sel_slot  = 3'd0;
    rr_ptr_nx = rr_ptr;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (free[i]) sel_slot = 3'(i);
    end
    if (|free) begin
      if (pend_l && pend_r) begin
        if (rr_ptr == OWNER_L) grant_l = 1'b1;
        else                   grant_r = 1'b1;
        rr_ptr_nx = ~rr_ptr;
      end else if (pend_l) begin
        grant_l = 1'b1;
      end else if (pend_r) begin
        grant_r = 1'b1;
      end
    end
  end

  // Reservation per slot: held until the engine reports busy or 4 idle cycles pass.
  always_ff @(posedge clk2) begin
    if (!Reset) begin
      reserved <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) age[i] <= 2'd0;
    end else begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (grant_any && sel_slot == 3'(i)) begin
          reserved[i] <= 1'b1;
          age[i]      <= 2'd0;
        end else if (reserved[i]) begin
          if (slot_busy[i] || age[i] == 2'd3) reserved[i] <= 1'b0;
          else                                age[i]      <= age[i] + 2'd1;
        end
      end
    end
  end

  // ---- stage p1: registered launch outputs, one cycle after the grant ----
  // Launch register and round-robin pointer.
  always_ff @(posedge clk2) begin
    if (!Reset) begin
      spawn_vld_p1   <= 1'b0;
      spawn_slot_p1  <= 3'd0;
      spawn_owner_p1 <= OWNER_L;
      shot_p1        <= '0;
      rr_ptr         <= OWNER_L;
    end else begin
      spawn_vld_p1 <= grant_any;
      rr_ptr       <= rr_ptr_nx;
      if (grant_any) begin
        spawn_slot_p1  <= sel_slot;
        spawn_owner_p1 <= grant_r ? OWNER_R : OWNER_L;
        shot_p1        <= shot_win;
      end
    end
  end

  assign spawn_valid = spawn_vld_p1;
  assign spawn_slot  = spawn_slot_p1;
  assign spawn_owner = spawn_owner_p1;
  assign spawn_pos_x = shot_p1.pos_x;
  assign spawn_pos_y = shot_p1.pos_y;
  assign spawn_vel_x = shot_p1.vel_x;
  assign spawn_vel_y = shot_p1.vel_y;

endmodule

// File: doc/turret_fire_sched.md
Name: turret_fire_sched

Overview:
- Schedules bullet launches from the two turrets (left, right) onto a shared pool of NUM_SLOTS bullet-motion engines.
- Sits between the key decode and turret-angle FSMs on one side and the bullet engines on the other.
- On each fire key press it captures the requesting turret's current muzzle position and velocity, then picks a turret by round-robin.
- It allocates the lowest free slot and enforces a per-turret cooldown.

Parameters:
- NUM_SLOTS, 4, number of bullet engines; 2..8
- COOLDOWN_CYC, 8, clk2 cycles a turret stays blocked after one of its spawns; 1..255
- MAX_AMMO, 15, shots per turret after reset; used only with the optional feature

Ports:
- clk2  in  1  block clock
- Reset  in  1  synchronous, active-low reset; sampled on the posedge of clk2
- fire_l  in  1  left fire key level; high while the key is held
- fire_r  in  1  right fire key level
- l_pos_x, l_pos_y  in  10  left muzzle spawn position, in pixels
- l_vel_x, l_vel_y  in  10  left bullet step per frame, 10-bit two's complement
- r_pos_x, r_pos_y, r_vel_x, r_vel_y  in  10 each  right turret equivalents
- slot_busy  in  NUM_SLOTS  bit i high while engine i has a live bullet
- spawn_valid  out  1  one-cycle launch pulse
- spawn_slot  out  3  index of the engine to load
- spawn_owner  out  1  0 = left, 1 = right
- spawn_pos_x, spawn_pos_y, spawn_vel_x, spawn_vel_y  out  10 each  launch payload
- busy_l, busy_r  out  1  turret is PENDING or COOLDOWN

Behaviour:
- Reset (Reset == 0 at a posedge):
  - spawn_valid = 0, spawn_slot = 0, spawn_owner = 0, all payload outputs = 0.
  - Both turret FSMs go to READY; RR pointer = left; reserved mask = 0; edge registers = 0.
  - Reset applied mid-operation discards pending requests and cooldowns; no spawn occurs in the reset cycle.
- Edge detect: a request is fire_x = 1 in cycle n with fire_x = 0 in cycle n-1. A held key gives exactly one request.
- Per-turret FSM:
  - READY -> PENDING on a request. In that same cycle the pos/vel inputs are latched; later angle changes do not alter the shot.
  - PENDING -> COOLDOWN in the cycle it is granted. The counter loads COOLDOWN_CYC-1.
  - COOLDOWN decrements each cycle and returns to READY when the counter is 0 (COOLDOWN_CYC cycles total).
  - Requests in PENDING or COOLDOWN are dropped, not queued.
- Slot availability:
  - free = ~slot_busy & ~reserved.
  - A spawn sets reserved[slot]. reserved[i] clears when slot_busy[i] is sampled high.
  - reserved[i] also clears after 4 cycles without busy, so a lost handshake cannot lock the slot.
- Grant (combinational decision, registered outputs):
  - At most one grant per cycle, made only if free != 0 and at least one turret is PENDING.
  - Only one PENDING: it wins. Both PENDING: the RR pointer side wins; the pointer then flips to the other side.
  - Chosen slot = lowest-index free bit.
- Outputs: registered; spawn_valid is high in the cycle after the grant, with payload and slot valid in that same cycle.
  - Minimum latency: request edge in cycle n -> PENDING at n+1 -> spawn_valid at n+2.
- No free slot: requests stay PENDING indefinitely. A slot that frees in cycle k can be granted in cycle k.
- Velocity and position pass through unmodified; the block does no arithmetic on them.
- Simultaneous edges from both turrets in one cycle: both latch into PENDING. The RR pointer decides the order, and the second spawn is at least 1 cycle later.

Optional Feature:
- Macro TURRET_FIRE_SCHED_AMMO_LIMIT_EN.
- Defined:
  - Adds outputs ammo_l and ammo_r, 4 bits each; both reset to MAX_AMMO.
  - Each grant decrements the owner's count.
  - A request while the count is 0 is dropped, and the FSM stays READY.
- Undefined: ammo ports are absent and firing is unlimited.

Decomposition:
- Shared package turret_pkg holds:
  - typedef turret_state_t {READY, PENDING, COOLDOWN}
  - owner encodings OWNER_L = 0, OWNER_R = 1
  - constant COORD_W = 10
- One sub-module, turret_req_fsm, instantiated twice. It contains edge detect, the payload latch, the cooldown counter and (optionally) the ammo counter, and exposes pending, payload and grant.

Test Plan:
- Single shot:
  - Stimulus: Reset low 2 cycles; r_pos = (510,420), r_vel = (0x3FF,0); pulse fire_r at cycle 10.
  - Required: spawn_valid at cycle 12 with slot 0, owner 1, payload (510,420,0x3FF,0); busy_r returns to 0 at cycle 20.
- Held key and cooldown:
  - Stimulus: hold fire_r for 30 cycles.
  - Required: exactly one spawn.
  - Stimulus: re-press 3 cycles after the spawn.
  - Required: dropped, no spawn.
- Round-robin:
  - Stimulus: fire_l and fire_r rise in the same cycle, with slot_busy = 0.
  - Required: left spawns to slot 0, right spawns to slot 1 one cycle later. A repeat after cooldown gives right first.
- Pool full:
  - Stimulus: slot_busy = 4'hF, then press fire_l.
  - Required: stays PENDING, no spawn.
  - Stimulus: drop slot_busy[2] at cycle k.
  - Required: spawn to slot 2 at k+1.
- Reset mid-PENDING:
  - Stimulus: assert Reset while both turrets are pending.
  - Required: no spawn afterwards and busy_l = busy_r = 0.
- Ammo feature:
  - Stimulus: MAX_AMMO = 2, fire_l three times, each separated by cooldown.
  - Required: two spawns, ammo_l = 0, third request ignored.
